// File: rtl/arb_pkg.sv
// arb_pkg: shared types and the round-robin search helper for rr_arbiter.
// Contents: arb_state_e (IDLE/GRANT), ARB_MAX_N, pick_t, rr_first().
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  localparam int ARB_MAX_N = 16;
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;
  // First set bit of vec at or after ptr, wrapping modulo n (n <= ARB_MAX_N).
  // Scanning offsets downward lets the smallest offset win without a break.
  function automatic pick_t rr_first(input logic [ARB_MAX_N-1:0] vec, input logic [3:0] ptr,
                                     input int n);
    rr_first = '0;
    for (int i = ARB_MAX_N - 1; i >= 0; i--)
      if (i < n && vec[4'((int'(ptr) + i) % n)]) rr_first = '{valid: 1'b1, idx: 4'((int'(ptr) + i) % n)};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational masked rotate-and-priority-encode.
// Ports: req (N) candidates, mask (N) bits to exclude, ptr search start,
//        winner index of first unmasked request from ptr upward, valid any found.
module rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);
  pick_t p;
  always_comb begin
    p = rr_first(ARB_MAX_N'(req & ~mask), 4'(ptr), N);
    winner = p.idx[W-1:0];
    valid = p.valid;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with hold limit and preemption.
// Ports: clk, rst_n (async active-low), req (N) requests,
//        grant (N) registered one-hot-or-zero, grant_id holder index (0 idle),
//        busy any grant, preempt one-cycle pulse when a still-requesting holder loses grant.
// Optional: define ARB_ASSERT_EN to compile concurrent protocol assertions.
module rr_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 preempt
);
  localparam int W = $clog2(N);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] LIMIT = HW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  arb_state_e state;
  logic [W-1:0] ptr, winner;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0] mask;
  logic valid, held, at_limit, hand_off;
  assign mask = state == GRANT ? grant : '0;
  assign held = state == GRANT && |(req & grant);
  assign at_limit = MAX_HOLD != 0 && hold_cnt == LIMIT;
  // Re-arbitrate when idle, on release, or when the hold limit meets a competitor.
  assign hand_off = !held || (at_limit && valid);
  rr_pick #(.N(N)) u_pick (.req(req), .mask(mask), .ptr(ptr), .winner(winner), .valid(valid));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      preempt <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else if (hand_off) begin
      state <= valid ? GRANT : IDLE;
      grant <= valid ? N'(1) << winner : '0;
      grant_id <= valid ? winner : '0;
      busy <= valid;
      preempt <= held && valid;
      if (valid) ptr <= winner == W'(N - 1) ? '0 : winner + 1'b1;
      hold_cnt <= '0;
    end else begin
      preempt <= 1'b0;
      hold_cnt <= hold_cnt == LIMIT ? hold_cnt : hold_cnt + 1'b1;
    end
  end
`ifdef ARB_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant))
    else $error("a_onehot");
  a_grant_req: assert property (@(posedge clk) disable iff (!rst_n) (grant & ~$past(req)) == '0)
    else $error("a_grant_req");
  a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == |grant)
    else $error("a_busy");
  a_preempt: assert property (@(posedge clk) disable iff (!rst_n) preempt |-> $past(req[grant_id]))
    else $error("a_preempt");
`endif
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed scoreboard bench for rr_arbiter (N=4, MAX_HOLD=4 and MAX_HOLD=0).
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] grant, grant_z;
  logic [1:0] grant_id, grant_id_z;
  logic busy, busy_z, preempt, preempt_z;
  logic sel = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  typedef struct packed {
    logic [3:0] g;
    logic       p;
  } exp_t;
  exp_t sb[$];

  rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .grant_id(grant_id),
    .busy(busy), .preempt(preempt));
  rr_arbiter #(.N(4), .MAX_HOLD(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant_z), .grant_id(grant_id_z),
    .busy(busy_z), .preempt(preempt_z));

  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic p);
    cmp({tag, "_grant"}, sel ? grant_z : grant, g);
    cmp({tag, "_grant_id"}, {2'b00, sel ? grant_id_z : grant_id}, {2'b00, idx_of(g)});
    cmp({tag, "_busy"}, {3'b000, sel ? busy_z : busy}, {3'b000, |g});
    cmp({tag, "_preempt"}, {3'b000, sel ? preempt_z : preempt}, {3'b000, p});
  endtask

  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] g, input logic p);
    exp_t e;
    req = r;
    sb.push_back({g, p});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(tag, e.g, e.p);
  endtask

  task automatic do_reset(input string tag, input logic [3:0] r);
    req = r;
    rst_n = 1'b0;
    #1;
    check_out({tag, "_async"}, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check_out({tag, "_held"}, 4'b0000, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset("reset", 4'b1111);
    step("reset_first", 4'b1111, 4'b0001, 1'b0);
    step("fair1", 4'b1110, 4'b0010, 1'b0);
    step("fair2", 4'b1101, 4'b0100, 1'b0);
    step("fair3", 4'b1011, 4'b1000, 1'b0);
    step("fair4", 4'b0111, 4'b0001, 1'b0);
    do_reset("rst_pre", 4'b0101);
    for (int i = 0; i < 4; i++) step("pre_a", 4'b0101, 4'b0001, 1'b0);
    step("pre_sw1", 4'b0101, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_b", 4'b0101, 4'b0100, 1'b0);
    step("pre_sw2", 4'b0101, 4'b0001, 1'b1);
    do_reset("rst_lone", 4'b0001);
    for (int i = 0; i < 10; i++) step("lone", 4'b0001, 4'b0001, 1'b0);
    step("lone_pre", 4'b1001, 4'b1000, 1'b1);
    do_reset("rst_mid", 4'b0100);
    step("mid_grant", 4'b0100, 4'b0100, 1'b0);
    req = 4'b1100;
    rst_n = 1'b0;
    #1;
    check_out("mid_drop", 4'b0000, 1'b0);
    #1;
    rst_n = 1'b1;
    step("mid_restart", 4'b1100, 4'b0100, 1'b0);
    sel = 1'b1;
    do_reset("rst_nohold", 4'b1010);
    for (int i = 0; i < 20; i++) step("nohold", 4'b1010, 4'b0010, 1'b0);
    step("nohold_rel", 4'b1000, 4'b1000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
